// File: rtl/hdr_frame_reader_if.sv
// Signal bundle between the frame reader, the SDRAM read port and the display pixel port.
// slave is the reader's view; master is the view of whatever drives it.
interface hdr_frame_reader_if;
    logic         frame_start;
    logic         hdr_last_frame;
    logic         ram_busy;
    logic         rd_req;
    logic [24:0]  rd_address;
    logic         rd_valid;
    logic [127:0] rd_data;
    logic         pix_req;
    logic         pix_valid;
    logic [15:0]  pixel_data;
    logic         frame_done;
    logic         underflow;

    modport slave (
        input  frame_start,
        input  hdr_last_frame,
        input  ram_busy,
        input  rd_valid,
        input  rd_data,
        input  pix_req,
        output rd_req,
        output rd_address,
        output pix_valid,
        output pixel_data,
        output frame_done,
        output underflow
    );

    modport master (
        output frame_start,
        output hdr_last_frame,
        output ram_busy,
        output rd_valid,
        output rd_data,
        output pix_req,
        input  rd_req,
        input  rd_address,
        input  pix_valid,
        input  pixel_data,
        input  frame_done,
        input  underflow
    );
endinterface

// File: rtl/hdr_frame_reader.sv
// Reads the double-buffered RGB565 frame the tone mapper is not writing, 8 pixels per
// 128-bit SDRAM word, and serves one byte-swapped pixel per display request.
module hdr_frame_reader #(
    parameter logic [24:0] BASE_ADDR   = 25'hE1000,
    parameter int unsigned FRAME_WORDS = 38400,
    parameter int unsigned ADDR_STEP   = 4,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    hdr_frame_reader_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [24:0] BUF1_ADDR = BASE_ADDR + 25'(FRAME_WORDS * ADDR_STEP);
    localparam logic [18:0] LAST_PIX  = 19'(FRAME_WORDS * 8 - 1);
    localparam logic [15:0] WORDS_END = 16'(FRAME_WORDS);
    // One slot is kept free for the single outstanding read.
    localparam logic [CNT_W-1:0] ISSUE_MAX = CNT_W'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {StIdle, StFill, StWait, StDone} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [24:0]        r_base;
    logic [15:0]        r_words_req;
    logic [18:0]        r_pix_idx;
    logic               r_stale;
    logic [127:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_pix_valid;
    logic [15:0]        r_pixel_data;
    logic               r_frame_done;
    logic               r_underflow;

    logic               w_fifo_empty;
    logic               w_in_fetch;
    logic               w_issue;
    logic               w_push;
    logic               w_serve;
    logic               w_starve;
    logic               w_pop;
    logic               w_last;
    logic [24:0]        w_rd_addr;
    logic [127:0]       w_head;
    logic [15:0]        w_pixel;

    assign w_fifo_empty = (r_count == '0);
    assign w_in_fetch   = (r_state == StFill) || (r_state == StWait);

    // A read still in flight from an aborted frame blocks new requests until it returns.
    assign w_issue = (r_state == StFill) && !bus.ram_busy && !r_stale &&
                     (r_count <= ISSUE_MAX) && !bus.frame_start;
    assign w_push  = bus.rd_valid && (r_state == StWait) && !r_stale && !bus.frame_start;

    assign w_serve  = bus.pix_req && !bus.frame_start && (r_state != StIdle) && !w_fifo_empty;
    assign w_starve = bus.pix_req && !bus.frame_start && w_in_fetch && w_fifo_empty;
    assign w_pop    = w_serve && (r_pix_idx[2:0] == 3'd7);
    assign w_last   = w_serve && (r_pix_idx == LAST_PIX);

    assign w_rd_addr = r_base + 25'(r_words_req) * 25'(ADDR_STEP);

    // Each 16-bit lane is stored little-endian; swap bytes to get {R,G,B}.
    assign w_head  = r_mem[r_rd_ptr];
    assign w_pixel = {w_head[{r_pix_idx[2:0], 4'd0} +: 8], w_head[{r_pix_idx[2:0], 4'd8} +: 8]};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: w_state_next = StIdle;
            StFill: if (w_issue) w_state_next = StWait;
            StWait: begin
                if (bus.rd_valid) begin
                    w_state_next = (r_words_req == WORDS_END) ? StDone : StFill;
                end
            end
            StDone: w_state_next = StDone;
            default: w_state_next = StIdle;
        endcase
        if (w_last) w_state_next = StIdle;
        if (bus.frame_start) w_state_next = StFill;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_base       <= BASE_ADDR;
            r_words_req  <= '0;
            r_pix_idx    <= '0;
            r_stale      <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_pix_valid  <= 1'b0;
            r_pixel_data <= '0;
            r_frame_done <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_stale <= (r_stale || (bus.frame_start && (r_state == StWait))) && !bus.rd_valid;
            if (bus.frame_start) begin
                r_base      <= bus.hdr_last_frame ? BASE_ADDR : BUF1_ADDR;
                r_words_req <= '0;
                r_pix_idx   <= '0;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
            end else begin
                if (w_issue) r_words_req <= r_words_req + 16'd1;
                if (w_serve) r_pix_idx <= r_pix_idx + 19'd1;
                if (w_push)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
            r_pix_valid  <= bus.pix_req;
            r_pixel_data <= w_serve ? w_pixel : 16'h0000;
            r_frame_done <= w_last;
            if (w_starve) r_underflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.rd_data;
    end

    assign bus.rd_req     = w_issue;
    assign bus.rd_address = w_rd_addr;
    assign bus.pix_valid  = r_pix_valid;
    assign bus.pixel_data = r_pixel_data;
    assign bus.frame_done = r_frame_done;
    assign bus.underflow  = r_underflow;
endmodule
